// File: rtl/uart_rle_sender.sv
// Framebuffer that streams its contents to a UART as (count, byte) pairs; run length is count+1.
// Macro RLE_COMPRESS_EN enables run merging; without it every byte goes out as its own (00, byte) pair.
module uart_rle_sender #(
    parameter int DISPLAY_SIZE = 1024,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [10:0]       pair_count,
    output logic              tx_start,
    output logic [7:0]        tx_byte,
    input  logic              tx_busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRIME     = 3'd1;
    localparam logic [2:0] SCAN      = 3'd2;
    localparam logic [2:0] EMIT_CNT  = 3'd3;
    localparam logic [2:0] GAP1      = 3'd4;
    localparam logic [2:0] EMIT_DATA = 3'd5;
    localparam logic [2:0] GAP2      = 3'd6;
    localparam logic [2:0] FINISH    = 3'd7;

    localparam logic [ADDR_W:0] FRAME_END = (ADDR_W+1)'(DISPLAY_SIZE);

    logic [7:0]        mem [DISPLAY_SIZE];
    logic [7:0]        rd_data_q;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_fire;
    logic              same_byte;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [7:0]        run_byte_q, run_byte_d;
    logic [7:0]        run_cnt_q, run_cnt_d;
    logic [7:0]        next_byte_q, next_byte_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [10:0]       pair_count_q, pair_count_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_byte_q, tx_byte_d;

    assign wr_fire = wr_en && !busy_q;
    // The read address runs one step ahead so rd_data_q always holds mem[idx_q].
    assign rd_addr = idx_d[ADDR_W-1:0];

    // A write in the same cycle as a read of that address is forwarded, so a
    // start issued alongside a write to address 0 scans the new value.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= (wr_fire && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end

    always_comb begin
        same_byte = 1'b0;
`ifdef RLE_COMPRESS_EN
        same_byte = (rd_data_q == run_byte_q) && (run_cnt_q != 8'hFF);
`endif
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        run_byte_d   = run_byte_q;
        run_cnt_d    = run_cnt_q;
        next_byte_d  = next_byte_q;
        last_d       = last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pair_count_d = pair_count_q;
        tx_start_d   = 1'b0;
        tx_byte_d    = tx_byte_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d        = '0;
                    pair_count_d = '0;
                    last_d       = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = PRIME;
                end
            end
            PRIME: begin
                run_byte_d = rd_data_q;
                run_cnt_d  = 8'd0;
                idx_d      = (ADDR_W+1)'(1);
                state_d    = SCAN;
            end
            SCAN: begin
                if (idx_q == FRAME_END) begin
                    last_d  = 1'b1;
                    state_d = EMIT_CNT;
                end else if (same_byte) begin
                    run_cnt_d = run_cnt_q + 8'd1;
                    idx_d     = idx_q + 1'b1;
                end else begin
                    next_byte_d = rd_data_q;
                    state_d     = EMIT_CNT;
                end
            end
            EMIT_CNT: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_byte_d  = run_cnt_q;
                    state_d    = GAP1;
                end
            end
            // The UART raises its busy flag one cycle late; this cycle skips it.
            GAP1: state_d = EMIT_DATA;
            EMIT_DATA: begin
                if (!tx_busy) begin
                    tx_start_d   = 1'b1;
                    tx_byte_d    = run_byte_q;
                    pair_count_d = pair_count_q + 11'd1;
                    state_d      = GAP2;
                end
            end
            GAP2: begin
                if (last_q) begin
                    state_d = FINISH;
                end else begin
                    run_byte_d = next_byte_q;
                    run_cnt_d  = 8'd0;
                    idx_d      = idx_q + 1'b1;
                    state_d    = SCAN;
                end
            end
            FINISH: begin
                if (!tx_busy) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            run_byte_q   <= 8'd0;
            run_cnt_q    <= 8'd0;
            next_byte_q  <= 8'd0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pair_count_q <= '0;
            tx_start_q   <= 1'b0;
            tx_byte_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            run_byte_q   <= run_byte_d;
            run_cnt_q    <= run_cnt_d;
            next_byte_q  <= next_byte_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pair_count_q <= pair_count_d;
            tx_start_q   <= tx_start_d;
            tx_byte_q    <= tx_byte_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pair_count = pair_count_q;
    assign tx_start   = tx_start_q;
    assign tx_byte    = tx_byte_q;

endmodule

// File: tb/tb_uart_rle_sender.sv
// Bench for uart_rle_sender: directed frames, a UART busy model and a run-length reference model.
`timescale 1ns/1ps
module tb_uart_rle_sender;

    localparam int N = 1024;
`ifdef RLE_COMPRESS_EN
    localparam bit RLE       = 1'b1;
    localparam int BASE_BUSY = 10;
    localparam int SLOW_BUSY = 40;
    localparam int SLOW_JIT  = 8;
`else
    localparam bit RLE       = 1'b0;
    localparam int BASE_BUSY = 2;
    localparam int SLOW_BUSY = 3;
    localparam int SLOW_JIT  = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        start = 1'b0;
    logic        busy, done, tx_start, tx_busy;
    logic [10:0] pair_count;
    logic [7:0]  tx_byte;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] frame [N];
    logic [7:0] exp_q [$];
    int exp_pairs = 0;

    int busy_len = BASE_BUSY;
    int stall_max = 0;
    int busy_cnt = 0;
    int tx_seen = 0;
    int done_seen = 0;
    bit prev_tx_start = 1'b0;

    always #5 clk = ~clk;

    uart_rle_sender dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pair_count (pair_count),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .tx_busy    (tx_busy)
    );

    // UART model: busy for busy_len (+ random stall) cycles after each accepted byte.
    assign tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= busy_len + int'($urandom_range(0, stall_max));
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Compare process: every byte handed to the UART is checked against the expected stream.
    always @(negedge clk) begin
        if (tx_start) begin
            check("tx_start_while_busy", int'(tx_busy), 0);
            check("tx_start_back_to_back", int'(prev_tx_start), 0);
            if (exp_q.size() == 0) check("tx_byte_unexpected", int'(tx_byte), -1);
            else check("tx_byte", int'(tx_byte), int'(exp_q.pop_front()));
            tx_seen <= tx_seen + 1;
        end
        if (done) done_seen <= done_seen + 1;
        prev_tx_start <= tx_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: greedy runs of equal bytes, capped at 256, never crossing the frame end.
    task automatic build_expected();
        int i, len;
        exp_q.delete();
        exp_pairs = 0;
        i = 0;
        while (i < N) begin
            len = 1;
            if (RLE) while (i + len < N && len < 256 && frame[i+len] == frame[i]) len++;
            exp_q.push_back(8'(len - 1));
            exp_q.push_back(frame[i]);
            exp_pairs++;
            i += len;
        end
    endtask

    task automatic load_frame();
        for (int a = 0; a < N; a++) begin
            wr_en = 1'b1;
            wr_addr = 10'(a);
            wr_data = frame[a];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bit with_write, input logic [7:0] wdata);
        int d0, budget;
        d0 = done_seen;
        budget = exp_pairs * (2 * (busy_len + stall_max) + 10) + 200;
        start = 1'b1;
        if (with_write) begin
            wr_en = 1'b1;
            wr_addr = '0;
            wr_data = wdata;
        end
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check({tag, "_busy_after_start"}, int'(busy), 1);
        for (int c = 0; c < budget && done_seen == d0; c++) tick();
        repeat (3) tick();
        check({tag, "_done_pulses"}, done_seen - d0, 1);
        check({tag, "_bytes_left"}, exp_q.size(), 0);
        check({tag, "_pair_count"}, int'(pair_count), exp_pairs);
        check({tag, "_busy_after_done"}, int'(busy), 0);
    endtask

    initial begin
        int t0, d0;
        logic [7:0] s3_lit [10];
        s3_lit = '{8'hFF, 8'h11, 8'h2B, 8'h11, 8'hFF, 8'h22, 8'hFF, 8'h22, 8'hD3, 8'h22};

        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_tx_byte", int'(tx_byte), 0);
        check("rst_pair_count", int'(pair_count), 0);
        rst = 1'b0;
        tick();

        // Scenario 1: all-zero frame.
        for (int a = 0; a < N; a++) frame[a] = 8'h00;
        build_expected();
        if (RLE) begin
            check("s1_model_len", exp_q.size(), 8);
            for (int k = 0; k < 8; k++) check("s1_model_byte", int'(exp_q[k]), (k % 2 == 0) ? 255 : 0);
        end else begin
            check("s1_model_len", exp_q.size(), 2048);
            check("s1_model_byte0", int'(exp_q[0]), 0);
            check("s1_model_byte2047", int'(exp_q[2047]), 0);
        end
        load_frame();
        run_frame("s1", 1'b0, 8'h00);
        check("s1_pair_count_lit", int'(pair_count), RLE ? 4 : 1024);

        // Scenario 2: alternating 0xAA/0x55.
        for (int a = 0; a < N; a++) frame[a] = (a % 2 == 0) ? 8'hAA : 8'h55;
        build_expected();
        check("s2_model_pairs", exp_pairs, 1024);
        check("s2_model_first", int'(exp_q[1]), 8'hAA);
        check("s2_model_last", int'(exp_q[2047]), 8'h55);
        load_frame();
        run_frame("s2", 1'b0, 8'h00);
        check("s2_pair_count_lit", int'(pair_count), 1024);

        // Scenario 3: 300 x 0x11 then 724 x 0x22.
        for (int a = 0; a < N; a++) frame[a] = (a < 300) ? 8'h11 : 8'h22;
        build_expected();
        if (RLE) begin
            check("s3_model_len", exp_q.size(), 10);
            for (int k = 0; k < 10; k++) check("s3_model_byte", int'(exp_q[k]), int'(s3_lit[k]));
        end else begin
            check("s3_model_pairs", exp_pairs, 1024);
            check("s3_model_b299", int'(exp_q[599]), 8'h11);
            check("s3_model_b300", int'(exp_q[601]), 8'h22);
        end
        load_frame();
        run_frame("s3", 1'b0, 8'h00);
        check("s3_pair_count_lit", int'(pair_count), RLE ? 5 : 1024);

        // Scenario 4: slow UART with random extra stalls, same frame as scenario 3.
        busy_len = SLOW_BUSY;
        stall_max = SLOW_JIT;
        build_expected();
        run_frame("s4", 1'b0, 8'h00);
        busy_len = BASE_BUSY;
        stall_max = 0;

        // Scenario 5: ignored start/write while busy, then reset after the 3rd byte.
        build_expected();
        t0 = tx_seen;
        d0 = done_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        wr_en = 1'b1;
        wr_addr = '0;
        wr_data = 8'h99;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        for (int c = 0; c < 2000 && tx_seen < t0 + 3; c++) tick();
        check("s5_third_tx_start", tx_seen - t0, 3);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("s5_rst_busy", int'(busy), 0);
        check("s5_rst_tx_start", int'(tx_start), 0);
        check("s5_rst_pair_count", int'(pair_count), 0);
        repeat (60) tick();
        check("s5_no_done", done_seen - d0, 0);
        check("s5_idle_busy", int'(busy), 0);
        check("s5_idle_pair_count", int'(pair_count), 0);
        build_expected();
        run_frame("s5_replay", 1'b0, 8'h00);

        // Scenario 6: write to address 0 in the same cycle as start.
        for (int a = 0; a < N; a++) frame[a] = 8'h00;
        load_frame();
        frame[0] = 8'h77;
        build_expected();
        check("s6_model_pairs", exp_pairs, RLE ? 5 : 1024);
        check("s6_model_first", int'(exp_q[1]), 8'h77);
        run_frame("s6", 1'b1, 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rle_sender.md
Name: uart_rle_sender

Overview:
- Transmit-side counterpart of the UART framebuffer loader: holds a 128x8-page OLED frame (1024 bytes) and streams it out over UART as run-length (count, byte) pairs.
- Pair format matches the receive side: count byte first, then data byte. The run length is count+1, so count 0 means 1 byte and count 255 means 256 bytes.
- Sits between a frame writer (logic or test harness) and the shared `uart` module's transmit interface (`transmit`, `tx_byte`, `is_transmitting`).

Parameters:
- DISPLAY_SIZE, 1024, frame length in bytes; must be a power of two and at most 1024.
- ADDR_W, 10, log2(DISPLAY_SIZE).

Ports:
- clk  in  1  system clock (12 MHz on board)
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  framebuffer write strobe; ignored while busy=1
- wr_addr  in  ADDR_W  framebuffer write address
- wr_data  in  8  framebuffer write data
- start  in  1  one-cycle pulse; begins transmitting the whole frame; ignored while busy=1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last byte of the last pair has been handed to the UART and accepted
- pair_count  out  11  number of pairs sent in the current/last frame; holds its value after done
- tx_start  out  1  one-cycle pulse to `uart.transmit`
- tx_byte  out  8  byte to the UART; stable from the tx_start cycle until the next tx_start
- tx_busy  in  1  `uart.is_transmitting`

Behaviour:
- Reset values:
  - busy=0, done=0, tx_start=0, tx_byte=0, pair_count=0, FSM=IDLE.
  - Framebuffer RAM contents are not cleared by reset; initial contents are undefined.
- Framebuffer:
  - Single RAM, synchronous write, synchronous read with 1-cycle latency.
  - The scan reads addresses 0..DISPLAY_SIZE-1 in order.
- FSM states:
  - IDLE: an accepted start sets rd_addr=0 and pair_count=0, then goes to PRIME.
  - PRIME: waits for the read data of address 0. Sets run_byte=data, run_cnt=0, idx=1, then goes to SCAN.
  - SCAN: if idx==DISPLAY_SIZE, sets last=1 and goes to EMIT_CNT. Otherwise reads mem[idx] with 1-cycle latency, then:
    - If data==run_byte and run_cnt<255: run_cnt++, idx++, stay in SCAN.
    - Else: latch data into next_byte and go to EMIT_CNT (idx is not advanced yet).
  - EMIT_CNT: waits until tx_busy==0, then pulses tx_start with tx_byte=run_cnt and goes to GAP1.
  - GAP1: ignores tx_busy for exactly one cycle (UART busy-flag latency), then goes to EMIT_DATA.
  - EMIT_DATA: waits until tx_busy==0, then pulses tx_start with tx_byte=run_byte, increments pair_count, and goes to GAP2.
  - GAP2: one cycle. Then:
    - If last=1: go to FINISH.
    - Else: run_byte=next_byte, run_cnt=0, idx++, go to SCAN.
  - FINISH: waits until tx_busy==0, then pulses done=1 for one cycle, clears busy, and goes to IDLE.
- Runs:
  - Never cross the frame end.
  - The maximum run of 256 bytes is split into multiple pairs.
  - For any frame, the sum of (count+1) over all pairs equals DISPLAY_SIZE exactly.
  - pair_count is in the range 4..1024 (range applies with RLE_COMPRESS_EN defined).
- UART handshake:
  - tx_start is never asserted while tx_busy==1.
  - tx_start is never asserted on two consecutive cycles.
- Simultaneous events:
  - start and wr_en in the same IDLE cycle: the write lands first, and the scan sees the new value.
  - start during busy=1: ignored, with no effect on the stream.
- Reset mid-frame:
  - Takes effect on the next edge: FSM to IDLE, tx_start/busy low, no done pulse, pair_count=0.
  - A UART byte already in flight completes; the module emits nothing more until a new start.
- Throughput: scanning costs at most 1 cycle per byte after PRIME; the UART is the bottleneck.

Optional Feature:
- Macro: RLE_COMPRESS_EN
- Defined: run-length encoding exactly as described in Behaviour.
- Undefined:
  - The SCAN comparison is forced false, so every byte is sent as its own pair (00, byte).
  - Each frame produces exactly 2048 UART bytes and pair_count=1024.
  - Ports and handshake are unchanged.

Test Plan:
1. Fill the frame with 0x00, pulse start, UART model busy for 10 cycles per byte.
   - UART must see FF 00 FF 00 FF 00 FF 00.
   - pair_count=4, one done pulse, busy low afterwards.
2. Alternating 0xAA/0x55 frame.
   - UART must see 1024 pairs: 00 AA 00 55 ... ending 00 55.
   - pair_count=1024.
3. Addresses 0..299 = 0x11, 300..1023 = 0x22.
   - UART must see FF 11 2B 11 FF 22 FF 22 D3 22.
   - pair_count=5.
4. Hold tx_busy high for 40 cycles after each tx_start, plus random extra stalls.
   - No tx_start while tx_busy=1 and never on consecutive cycles.
   - Byte sequence identical to scenario 3.
5. Scenario 3 with rst asserted 1 cycle after the 3rd tx_start; also pulse start and wr_en at addr 0 during busy before the reset.
   - Both the mid-frame start and the write are ignored.
   - After the reset: busy=0, done never pulses, pair_count=0.
   - A fresh start replays the full scenario-3 sequence.
6. Build without RLE_COMPRESS_EN, all-0x00 frame.
   - UART sees 2048 bytes, all 00.
   - pair_count=1024, done pulses once.
